// File: rtl/serial_adder_seq.sv
// Digit-serial adder: WIDTH-bit a + b + cin, DIGIT bits per clock, with
// valid/ready handshakes on both sides and the result held until taken.
module serial_adder_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   dig_sum;
  logic [WIDTH-1:0] dig_ext;
  logic             msb_cin;
  logic             accept;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    dig_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    dig_ext = WIDTH'(dig_sum[DIGIT-1:0]);
    // Carry into the top bit of this digit, recovered from its sum bit.
    msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1];

    case (state_q)
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = (sum_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
        carry_d = dig_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
          ovf_d   = msb_cin ^ dig_sum[DIGIT];
        end
      end
      DONE: begin
        if (out_ready && !accept) state_d = IDLE;
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or from DONE while the result is taken.
    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: three instances (8/1, 1/1, 8/4) checked against
// an integer-arithmetic model with table, hand-written and random vectors.
module tb_serial_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] iv, ordy, ci;
  logic [7:0] a0, b0, a2, b2;
  logic       a1, b1;
  wire  [2:0] ird, ovl, cow, ovfw, bsy;
  wire  [7:0] s0, s2;
  wire        s1;

  serial_adder_seq #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ird[0]), .a(a0), .b(b0),
    .cin(ci[0]), .out_valid(ovl[0]), .out_ready(ordy[0]), .sum(s0), .cout(cow[0]),
    .ovf(ovfw[0]), .busy(bsy[0]));

  serial_adder_seq #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ird[1]), .a(a1), .b(b1),
    .cin(ci[1]), .out_valid(ovl[1]), .out_ready(ordy[1]), .sum(s1), .cout(cow[1]),
    .ovf(ovfw[1]), .busy(bsy[1]));

  serial_adder_seq #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ird[2]), .a(a2), .b(b2),
    .cin(ci[2]), .out_valid(ovl[2]), .out_ready(ordy[2]), .sum(s2), .cout(cow[2]),
    .ovf(ovfw[2]), .busy(bsy[2]));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer addition in a w-bit field.
  function automatic void model(input int w, input int a, input int b, input int c,
                                output int s, output int co, output int ov);
    int m, tot, sa, sb, sr;
    m   = 1 << w;
    tot = a + b + c;
    s   = tot % m;
    co  = tot / m;
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sr  = sa + sb + c;
    ov  = (sr > m / 2 - 1 || sr < -(m / 2)) ? 1 : 0;
  endfunction

  function automatic logic [7:0] get_sum(input int w);
    case (w)
      0:       return s0;
      1:       return {7'b0, s1};
      default: return s2;
    endcase
  endfunction

  task automatic set_in(input int w, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    iv[w] = v;
    ci[w] = c;
    case (w)
      0:       begin a0 = a;    b0 = b;    end
      1:       begin a1 = a[0]; b1 = b[0]; end
      default: begin a2 = a;    b2 = b;    end
    endcase
  endtask

  // lat = rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(input int w, output int lat);
    lat = 0;
    while (!ovl[w] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!ovl[w]) check("result_timeout", 32'(ovl[w]), 32'd1);
  endtask

  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] s, output logic co, output logic ov, output int lat);
    int k;
    k = 0;
    @(negedge clk);
    set_in(w, 1'b1, a, b, c);
    while (!ird[w] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ird[w]) check("accept_timeout", 32'(ird[w]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_result(w, lat);
    s  = get_sum(w);
    co = cow[w];
    ov = ovfw[w];
    ordy[w] = 1'b1;
    @(negedge clk);
    ordy[w] = 1'b0;
  endtask

  initial begin
    vec_t       tbl[4];
    logic [7:0] s, ra, rb;
    logic       co, ov, rc;
    int         lat, es, eco, eov;

    tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    tbl[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};

    rst_n = 1'b0;
    iv = '0; ordy = '0; ci = '0;
    a0 = '0; b0 = '0; a1 = 1'b0; b1 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(ovl[0]), 32'd0);
    check("rst_busy",      32'(bsy[0]), 32'd0);
    check("rst_in_ready",  32'(ird[0]), 32'd1);
    check("rst_sum",       32'(s0),     32'd0);
    check("rst_cout",      32'(cow[0]), 32'd0);
    check("rst_ovf",       32'(ovfw[0]), 32'd0);
    rst_n = 1'b1;

    // out_ready with nothing pending must not produce a result.
    ordy[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ordy_valid", 32'(ovl[0]), 32'd0);
    check("idle_ordy_ready", 32'(ird[0]), 32'd1);
    ordy[0] = 1'b0;

    // out_valid rises on the 8th edge after the accept edge (9th counting it).
    for (int i = 0; i < 4; i++) begin
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, lat);
      check($sformatf("tbl%0d_sum", i),  32'(s),  32'(tbl[i].sum));
      check($sformatf("tbl%0d_cout", i), 32'(co), 32'(tbl[i].cout));
      check($sformatf("tbl%0d_ovf", i),  32'(ov), 32'(tbl[i].ovf));
      check($sformatf("tbl%0d_lat", i),  32'(lat), 32'd8);
    end

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      do_op(0, ra, rb, rc, s, co, ov, lat);
      model(8, int'(ra), int'(rb), int'(rc), es, eco, eov);
      check("rnd8_sum",  32'(s),  32'(es));
      check("rnd8_cout", 32'(co), 32'(eco));
      check("rnd8_ovf",  32'(ov), 32'(eov));
    end

    // Result held in DONE while in_valid is high but out_ready is low.
    @(negedge clk);
    set_in(0, 1'b1, 8'h3C, 8'h41, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_result(0, lat);
    set_in(0, 1'b1, 8'hA5, 8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(ovl[0]), 32'd1);
      check("hold_sum",   32'(s0),     32'h7E);
      check("hold_busy",  32'(bsy[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    #1;
    check("b2b_in_ready", 32'(ird[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    check("b2b_busy",  32'(bsy[0]), 32'd1);
    check("b2b_valid", 32'(ovl[0]), 32'd0);
    set_in(0, 1'b1, 8'h11, 8'h11, 1'b1);
    #1;
    check("run_in_ready", 32'(ird[0]), 32'd0);
    wait_result(0, lat);
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("b2b_lat",  32'(lat),     32'd8);
    check("b2b_sum",  32'(s0),      32'hFF);
    check("b2b_cout", 32'(cow[0]),  32'd0);
    check("b2b_ovf",  32'(ovfw[0]), 32'd0);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    set_in(0, 1'b1, 8'h55, 8'h22, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ovl[0]), 32'd0);
    check("midrst_busy",  32'(bsy[0]), 32'd0);
    check("midrst_ready", 32'(ird[0]), 32'd1);
    check("midrst_sum",   32'(s0),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 8'h03, 8'h04, 1'b0, s, co, ov, lat);
    check("postrst_sum", 32'(s),   32'h07);
    check("postrst_lat", 32'(lat), 32'd8);

    // WIDTH=1: full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      do_op(1, {7'b0, i[2]}, {7'b0, i[1]}, i[0], s, co, ov, lat);
      model(1, int'(i[2]), int'(i[1]), int'(i[0]), es, eco, eov);
      check($sformatf("fa%0d_sum", i),  32'(s),  32'(es));
      check($sformatf("fa%0d_cout", i), 32'(co), 32'(eco));
      check($sformatf("fa%0d_ovf", i),  32'(ov), 32'(eov));
      check($sformatf("fa%0d_lat", i),  32'(lat), 32'd1);
    end

    // WIDTH=8, DIGIT=4: two-digit latency, random sweep.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      do_op(2, ra, rb, rc, s, co, ov, lat);
      model(8, int'(ra), int'(rb), int'(rc), es, eco, eov);
      check("d4_sum",  32'(s),   32'(es));
      check("d4_cout", 32'(co),  32'(eco));
      check("d4_ovf",  32'(ov),  32'(eov));
      check("d4_lat",  32'(lat), 32'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
